// File: rtl/booth_mac_accum_if.sv
// Product-in / result-out bus for booth_mac_accum.
// master = producer/consumer side, slave = the accumulator.
interface booth_mac_accum_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              clear;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_ovf;

    modport master (
        output prod_valid, prod_data, clear, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_ovf
    );

    modport slave (
        input  prod_valid, prod_data, clear, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_ovf
    );
endinterface

// File: rtl/booth_mac_accum.sv
// booth_mac_accum: accumulates LEN signed products into an ACC_W result and
// hands the sum out on a valid/ready port with a sticky overflow flag.
// Optional build macro BOOTH_MAC_SAT_EN: saturate on overflow instead of wrap.
module booth_mac_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input logic               clk,
    input logic               rst,
    booth_mac_accum_if.slave  bus
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q;
    logic               sticky_q, sticky_d;
    logic               acc_valid_q;
    logic [ACC_W-1:0]   acc_data_q;
    logic               acc_ovf_q;

    logic [ACC_W-1:0]   addend, sum;
    logic               add_ovf;
    logic               fire, last;

    // Ready depends only on state, clear and reset, never on prod_valid.
    assign bus.prod_ready = (state_q == ACCUM) & ~bus.clear & ~rst;
    assign fire           = bus.prod_valid & bus.prod_ready;
    assign last           = (count_q == CNT_W'(LEN - 1));

    assign bus.acc_valid  = acc_valid_q;
    assign bus.acc_data   = acc_data_q;
    assign bus.acc_ovf    = acc_ovf_q;

    // Sign-extended add with same-sign-in / different-sign-out overflow test.
    always_comb begin
        addend               = {ACC_W{bus.prod_data[PROD_W-1]}};
        addend[PROD_W-1:0]   = bus.prod_data;
        sum                  = acc_q + addend;
        add_ovf              = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                               (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef BOOTH_MAC_SAT_EN
        // Both addends share a sign on overflow, so acc's sign picks the rail.
        acc_d                = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
        acc_d                = sum;
`endif
        sticky_d             = sticky_q | add_ovf;
    end

    // Run control: accumulate in ACCUM, publish and hold the result in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
            acc_ovf_q   <= 1'b0;
        end else if (bus.clear) begin
            // Abort: drop the partial run and any unconsumed result.
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (fire) begin
                        if (last) begin
                            acc_data_q  <= acc_d;
                            acc_ovf_q   <= sticky_d;
                            acc_valid_q <= 1'b1;
                            state_q     <= HOLD;
                            acc_q       <= '0;
                            count_q     <= '0;
                            sticky_q    <= 1'b0;
                        end else begin
                            acc_q       <= acc_d;
                            count_q     <= count_q + CNT_W'(1);
                            sticky_q    <= sticky_d;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        acc_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum: a 24-bit instance for normal runs and an 18-bit
// instance for overflow; results come from an arithmetic reference model.
module tb_booth_mac_accum;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_mac_accum_if #(.PROD_W(16), .ACC_W(24)) ifa ();
    booth_mac_accum_if #(.PROD_W(16), .ACC_W(18)) ifb ();

    booth_mac_accum #(.PROD_W(16), .ACC_W(24), .LEN(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    booth_mac_accum #(.PROD_W(16), .ACC_W(18), .LEN(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_chk  = 0;
    int n_fail = 0;
    int last_wait;

    // Reference: exact integer sum, out-of-range steps flag overflow, then wrap or clamp.
    function automatic void model(input iq_t q, input int w, output longint res, output bit ovf);
        longint mx, mn, acc, s;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -(longint'(1) <<< (w - 1));
        acc = 0;
        ovf = 0;
        foreach (q[i]) begin
            s = acc + longint'(q[i]);
            if (s > mx || s < mn) begin
                ovf = 1;
`ifdef BOOTH_MAC_SAT_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
`endif
            end
            acc = s;
        end
        res = acc;
    endfunction

    function automatic iq_t rep(input int v, input int n);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(v);
        return q;
    endfunction

    task automatic drv(input bit b, input logic v, input logic [15:0] d, input logic c, input logic r);
        if (b) begin
            ifb.prod_valid = v; ifb.prod_data = d; ifb.clear = c; ifb.acc_ready = r;
        end else begin
            ifa.prod_valid = v; ifa.prod_data = d; ifa.clear = c; ifa.acc_ready = r;
        end
    endtask

    function automatic logic rdy(input bit b);
        return b ? ifb.prod_ready : ifa.prod_ready;
    endfunction
    function automatic logic av(input bit b);
        return b ? ifb.acc_valid : ifa.acc_valid;
    endfunction
    function automatic logic ao(input bit b);
        return b ? ifb.acc_ovf : ifa.acc_ovf;
    endfunction
    function automatic longint ad(input bit b);
        if (b) return longint'($signed(ifb.acc_data));
        return longint'($signed(ifa.acc_data));
    endfunction

    // Stream one run (optional random gaps), check result and latency, stall, consume.
    task automatic run(input bit b, input iq_t q, input int gap, input int stall, input string nm);
        longint er, d0;
        bit     eo;
        int     n;
        model(q, b ? 18 : 24, er, eo);
        foreach (q[i]) begin
            n = (gap > 0) ? int'($urandom_range(gap)) : 0;
            repeat (n) begin @(negedge clk); drv(b, 1'b0, 16'd0, 1'b0, 1'b0); end
            @(negedge clk); drv(b, 1'b1, 16'(q[i]), 1'b0, 1'b0); #1;
            n = 0;
            while (!rdy(b) && n < 20) begin @(negedge clk); #1; n++; end
            if (i == 0) last_wait = n;
            if (n == 20) begin
                n_chk++; n_fail++;
                $display("FAIL %s handshake_timeout: beat %0d never accepted", nm, i);
            end
            if (i == q.size() - 1) begin
                n_chk++;
                if (av(b) !== 1'b0) begin
                    n_fail++; $display("FAIL %s early_valid: got %b required 0", nm, av(b));
                end
            end
            @(posedge clk);
        end
        #1;
        n_chk++;
        if (av(b) !== 1'b1) begin n_fail++; $display("FAIL %s latency: acc_valid %b required 1", nm, av(b)); end
        n_chk++;
        if (ad(b) !== er) begin n_fail++; $display("FAIL %s acc_data: got %0d required %0d", nm, ad(b), er); end
        n_chk++;
        if (ao(b) !== eo) begin n_fail++; $display("FAIL %s acc_ovf: got %b required %b", nm, ao(b), eo); end
        @(negedge clk); drv(b, stall > 0, 16'd2, 1'b0, 1'b0);
        d0 = ad(b);
        repeat (stall) begin
            @(negedge clk); #1;
            n_chk++;
            if (av(b) !== 1'b1 || ad(b) !== d0 || rdy(b) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall: valid %b data %0d ready %b required 1 %0d 0", nm, av(b), ad(b), rdy(b), d0);
            end
        end
        @(negedge clk); drv(b, stall > 0, 16'd2, 1'b0, 1'b1);
        @(posedge clk); #1; drv(b, stall > 0, 16'd2, 1'b0, 1'b0);
        n_chk++;
        if (av(b) !== 1'b0) begin n_fail++; $display("FAIL %s consume: acc_valid %b required 0", nm, av(b)); end
    endtask

    task automatic test_reset();
        drv(0, 1'b0, 16'd0, 1'b0, 1'b0);
        drv(1, 1'b0, 16'd0, 1'b0, 1'b0);
        #1;
        n_chk++;
        if (ifa.acc_valid !== 1'b0 || ifa.acc_data !== 24'd0 || ifa.acc_ovf !== 1'b0 || ifa.prod_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid %b data %0d ovf %b ready %b required 0 0 0 0",
                     ifa.acc_valid, ifa.acc_data, ifa.acc_ovf, ifa.prod_ready);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        iq_t q;
        for (int i = 1; i <= 8; i++) q.push_back(i);
        run(0, q, 0, 0, "basic");
    endtask

    task automatic test_negative();
        run(0, rep(-16384, 8), 0, 0, "negative");
    endtask

    task automatic test_overflow();
        run(1, rep(16384, 8), 0, 0, "overflow");
        run(1, rep(1, 8), 0, 0, "ovf_clean");
    endtask

    task automatic test_midrun_reset();
        // Leave a flagged result on B so the ovf clear is observable.
        run(1, rep(16384, 8), 0, 0, "ovf_again");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drv(0, 1'b1, 16'd1, 1'b0, 1'b0); @(posedge clk);
        end
        @(negedge clk); drv(0, 1'b0, 16'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (ifa.acc_valid !== 1'b0 || ifa.acc_data !== 24'd0 || ifa.acc_ovf !== 1'b0 || ifa.prod_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: valid %b data %0d ovf %b ready %b required 0 0 0 0",
                     ifa.acc_valid, ifa.acc_data, ifa.acc_ovf, ifa.prod_ready);
        end
        n_chk++;
        if (ifb.acc_ovf !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_ovf: got %b required 0", ifb.acc_ovf); end
        @(negedge clk); rst = 1'b0;
        run(0, rep(1, 8), 0, 0, "after_reset");
    endtask

    task automatic test_backpressure();
        run(0, rep(3, 8), 0, 5, "bp_hold");
        run(0, rep(2, 8), 0, 0, "bp_next");
        n_chk++;
        if (last_wait !== 0) begin n_fail++; $display("FAIL bp_turnaround: waited %0d cycles required 0", last_wait); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drv(0, 1'b1, 16'd100, 1'b0, 1'b0); @(posedge clk);
        end
        @(negedge clk); drv(0, 1'b1, 16'd100, 1'b1, 1'b0); #1;
        n_chk++;
        if (ifa.prod_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b required 0", ifa.prod_ready); end
        @(posedge clk);
        @(negedge clk); drv(0, 1'b0, 16'd0, 1'b0, 1'b0);
        run(0, rep(5, 8), 0, 0, "after_clear");
        // Clear while holding an unconsumed result.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drv(0, 1'b1, 16'd7, 1'b0, 1'b0); @(posedge clk);
        end
        @(negedge clk); drv(0, 1'b0, 16'd0, 1'b1, 1'b0);
        @(posedge clk); #1; drv(0, 1'b0, 16'd0, 1'b0, 1'b0);
        n_chk++;
        if (ifa.acc_valid !== 1'b0 || ifa.acc_data !== 24'd56) begin
            n_fail++; $display("FAIL clear_hold: valid %b data %0d required 0 56", ifa.acc_valid, ifa.acc_data);
        end
        run(0, rep(1, 8), 0, 0, "after_hold_clear");
    endtask

    task automatic test_random();
        iq_t q;
        for (int r = 0; r < 9; r++) begin
            q = {};
            for (int i = 0; i < 8; i++) q.push_back(int'($signed(16'($urandom))));
            run(r >= 3, q, 2, int'($urandom_range(3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_midrun_reset();
        test_backpressure();
        test_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_mac_accum.md
Name: booth_mac_accum

Overview:
- Downstream consumer of the signed 8x8 Booth multiplier's 16-bit product.
- Accumulates a fixed-length run of signed products (dot product) into a wider accumulator.
- Presents the finished sum on a valid/ready output port.
- Input side is valid/ready, so the combinational multiplier output can be registered and streamed in one product per cycle.

Parameters:
- PROD_W, 16, width of signed product input; must be ≤ ACC_W.
- ACC_W, 24, width of signed accumulator and result.
- LEN, 8, products per result; LEN ≥ 1.
- CNT_W, $clog2(LEN+1), term-counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset.
- prod_valid  input  1  product beat valid.
- prod_ready  output  1  block can accept a product this cycle.
- prod_data  input  PROD_W  signed product, two's complement.
- clear  input  1  synchronous abort of the current run.
- acc_valid  output  1  result valid.
- acc_ready  input  1  downstream accepts result.
- acc_data  output  ACC_W  signed accumulated result.
- acc_ovf  output  1  arithmetic overflow occurred during this result's run.

Behaviour:
- One clock domain.
- Reset is asynchronous and active-high. rst is asynchronous, active-high, and applies instantly.
- Reset values:
  - state = ACCUM
  - acc = 0, count = 0
  - acc_valid = 0, acc_data = 0, acc_ovf = 0
  - prod_ready = 0 while rst is high.
- States: ACCUM, HOLD.
- prod_ready = (state == ACCUM) & ~clear & ~rst. This is combinational from state and clear; there is no combinational path from prod_valid.
- In ACCUM, on prod_valid & prod_ready:
  - acc <= acc + sign_extend(prod_data) at ACC_W.
  - count <= count + 1.
  - Overflow detected when both addends have the same sign and the sum's sign differs; this sets a sticky ovf flag.
- Last term (count == LEN-1) with handshake:
  - acc_data <= final sum.
  - acc_ovf <= sticky flag, including this beat.
  - acc_valid <= 1.
  - state <= HOLD.
  - acc, count and sticky flag are cleared to 0.
- Latency: acc_valid rises the cycle after the LEN-th accepted product.
- LEN = 1: every accepted product goes straight to HOLD.
- In HOLD:
  - prod_ready = 0; no products are accepted.
  - acc_data and acc_ovf are held stable while acc_valid & ~acc_ready.
  - On acc_valid & acc_ready: acc_valid <= 0 and state <= ACCUM.
  - The next product is accepted no earlier than the following cycle, giving a one-bubble turnaround.
- acc_data and acc_ovf are not cleared on consume; they keep their last value while acc_valid = 0.
- Gaps (prod_valid low) leave acc and count unchanged.
- clear (synchronous, highest priority after rst):
  - acc = 0, count = 0, sticky flag = 0.
  - acc_valid = 0 and state = ACCUM, including in HOLD, where the unconsumed result is dropped.
  - A product presented in the same cycle as clear is not accepted.
  - acc_data and acc_ovf keep their old values.
- Wrap rule (SAT_EN off): sums wrap modulo 2^ACC_W.

Optional Feature:
- Macro: BOOTH_MAC_SAT_EN.
- Defined: each addition that overflows clamps acc to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Later terms continue from the clamped value. acc_ovf still reports that saturation occurred.
- Undefined: two's-complement wrap, and acc_ovf reports the wrap.
- The port list is identical in both builds.

Test Plan:
- Reset: assert rst mid-run after 3 products.
  - Required: acc_valid, acc_data and acc_ovf go to 0 immediately and prod_ready = 0.
  - After release, 8 products of 1 give acc_data = 8.
- Basic (LEN=8, ACC_W=24): products 1..8 back-to-back.
  - Required: acc_valid = 1 exactly one cycle after the 8th handshake, acc_data = 36, acc_ovf = 0.
- Negative: 8 products of -16384 (= -128 × 128).
  - Required: acc_data = 24'hFE0000 (-131072), acc_ovf = 0.
- Backpressure: hold acc_ready low for 5 cycles with the next product's prod_valid already high.
  - Required: acc_valid and acc_data stable and prod_ready = 0 during the stall.
  - After the consume cycle, the next product is accepted the following cycle and the new run starts from 0: 8 products of 2 give 16.
- Overflow (ACC_W=18): 8 products of 16384.
  - Without the macro: acc_data = -131072, acc_ovf = 1.
  - With BOOTH_MAC_SAT_EN: acc_data = 131071, acc_ovf = 1.
  - On the next clean run: acc_ovf = 0.
- Clear: pulse clear after 3 products of 100, including one cycle where prod_valid is high with clear.
  - Required: that beat is not accepted, and the next 8 products of 5 give acc_data = 40.
  - Clear issued in HOLD drops acc_valid without a consume.
